// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD to Excess-3 conversion path.
// Used by both the single-digit lookup and the word sequencer.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [3:0] XS3_OFFSET  = 4'd3;
    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam logic [3:0] XS3_INVALID = 4'd0;

endpackage

// File: rtl/xs3_digit_lut.sv
// Single-digit BCD to Excess-3 conversion; codes above 9 give a defined zero
// result plus an invalid flag so nothing downstream ever sees X.
module xs3_digit_lut
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] xs3_o,
    output logic       invalid_o
);

    assign invalid_o = (digit_i > BCD_MAX);
    assign xs3_o     = invalid_o ? XS3_INVALID : (digit_i + XS3_OFFSET);

endmodule

// File: rtl/bcd_xs3_seq.sv
// Converts a packed NDIG-digit BCD word to Excess-3 one digit per clock,
// least significant digit first, through one shared digit lookup.
module bcd_xs3_seq
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*NDIG-1:0] in_bcd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*NDIG-1:0] out_xs3,
    output logic              out_err,
    output logic [NDIG-1:0]   out_err_mask
);

    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_e              state_q, state_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [4*NDIG-1:0]   word_q, word_d;
    logic [4*NDIG-1:0]   xs3_q, xs3_d;
    logic [NDIG-1:0]     mask_q, mask_d;

    logic [3:0]          cur_digit;
    logic [3:0]          lut_xs3;
    logic                lut_inv;

    // Digit selection as a compare-per-digit mux keeps every slice in range
    // even when IDXW can address more digits than NDIG.
    always_comb begin
        cur_digit = 4'd0;
        for (int k = 0; k < NDIG; k++) begin
            if (idx_q == IDXW'(k)) begin
                cur_digit = word_q[4*k +: 4];
            end
        end
    end

    xs3_digit_lut u_lut (
        .digit_i   (cur_digit),
        .xs3_o     (lut_xs3),
        .invalid_o (lut_inv)
    );

    always_comb begin
        // NOTE: every next-state variable gets its hold value first, so no
        // path through the case below can leave one unassigned (no latches).
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        xs3_d   = xs3_q;
        mask_d  = mask_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    word_d  = in_bcd;
                    xs3_d   = '0;
                    mask_d  = '0;
                    idx_d   = '0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                for (int k = 0; k < NDIG; k++) begin
                    if (idx_q == IDXW'(k)) begin
                        xs3_d[4*k +: 4] = lut_xs3;
                        mask_d[k]       = lut_inv;
                    end
                end
                if (idx_q == IDXW'(NDIG - 1)) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            word_q  <= '0;
            xs3_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            xs3_q   <= xs3_d;
            mask_q  <= mask_d;
        end
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign out_valid    = (state_q == ST_DONE);
    assign out_xs3      = xs3_q;
    assign out_err_mask = mask_q;
    assign out_err      = |mask_q;

endmodule

// File: tb/tb_bcd_xs3_seq.sv
// Scoreboard bench for bcd_xs3_seq (NDIG=4 and NDIG=1) and its digit lookup.
module tb_bcd_xs3_seq;

    typedef struct {
        logic [63:0] xs3;
        logic [15:0] mask;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   seen4 = 0;
    int   seen1 = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // NDIG=4 instance
    logic        in_valid, in_ready, out_valid, out_ready, out_err;
    logic [15:0] in_bcd, out_xs3;
    logic [3:0]  out_err_mask;

    bcd_xs3_seq #(.NDIG(4)) dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_bcd       (in_bcd),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_xs3      (out_xs3),
        .out_err      (out_err),
        .out_err_mask (out_err_mask)
    );

    // NDIG=1 instance
    logic       in_valid1, in_ready1, out_valid1, out_ready1, out_err1;
    logic [3:0] in_bcd1, out_xs31;
    logic [0:0] out_err_mask1;

    bcd_xs3_seq #(.NDIG(1)) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid1),
        .in_ready     (in_ready1),
        .in_bcd       (in_bcd1),
        .out_valid    (out_valid1),
        .out_ready    (out_ready1),
        .out_xs3      (out_xs31),
        .out_err      (out_err1),
        .out_err_mask (out_err_mask1)
    );

    logic [3:0] lut_in, lut_out;
    logic       lut_inv;

    xs3_digit_lut u_lut (
        .digit_i   (lut_in),
        .xs3_o     (lut_out),
        .invalid_o (lut_inv)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: each digit below 10 becomes digit+3, anything else becomes 0 and flags.
    function automatic exp_t ref_model(input logic [63:0] w, input int nd);
        exp_t e;
        int   d;
        e.xs3  = '0;
        e.mask = '0;
        for (int k = 0; k < nd; k++) begin
            d = int'((w >> (4 * k)) & 64'hF);
            if (d <= 9) e.xs3 = e.xs3 | (64'(d + 3) << (4 * k));
            else        e.mask[k] = 1'b1;
        end
        return e;
    endfunction

    // Input side: whatever the DUT accepts gets its expected result queued.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready)   q4.push_back(ref_model(64'(in_bcd), 4));
        if (rst_n && in_valid1 && in_ready1) q1.push_back(ref_model(64'(in_bcd1), 1));
    end

    // Output side: every completed out handshake is compared against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (q4.size() == 0) begin
                check("dut4_spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e = q4.pop_front();
                check("dut4_xs3", 64'(out_xs3), 64'(e.xs3[15:0]));
                check("dut4_mask", 64'(out_err_mask), 64'(e.mask[3:0]));
                check("dut4_err", 64'(out_err), 64'(|e.mask[3:0]));
                seen4++;
            end
        end
        if (rst_n && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                check("dut1_spurious_out", 64'(out_valid1), 64'd0);
            end else begin
                e = q1.pop_front();
                check("dut1_xs3", 64'(out_xs31), 64'(e.xs3[3:0]));
                check("dut1_mask", 64'(out_err_mask1), 64'(e.mask[0]));
                check("dut1_err", 64'(out_err1), 64'(e.mask[0]));
                seen1++;
            end
        end
    end

    // A word in flight at reset is discarded, so its expectation goes too.
    always @(negedge rst_n) begin
        q4.delete();
        q1.delete();
    end

    task automatic send4(input logic [15:0] w, output int acc);
        int n;
        in_bcd   = w;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("dut4_accept_timeout", 64'(in_ready), 64'd1);
        acc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send1(input logic [3:0] w, output int acc);
        int n;
        in_bcd1   = w;
        in_valid1 = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready1) check("dut1_accept_timeout", 64'(in_ready1), 64'd1);
        acc = cyc;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
    endtask

    task automatic drain4();
        int n;
        n = 0;
        while ((q4.size() != 0 || !in_ready) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("dut4_drain", 64'(q4.size()), 64'd0);
    endtask

    task automatic drain1();
        int n;
        n = 0;
        while ((q1.size() != 0 || !in_ready1) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("dut1_drain", 64'(q1.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int          acc;
        int          n;
        int          accs[10];
        int          base;
        logic [15:0] w;
        bit          rnd_done;

        in_valid   = 1'b0;
        in_bcd     = '0;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        in_bcd1    = '0;
        out_ready1 = 1'b0;
        lut_in     = '0;

        for (int d = 0; d < 16; d++) begin
            lut_in = 4'(d);
            #1;
            check("lut_xs3", 64'(lut_out), (d <= 9) ? 64'(d + 3) : 64'd0);
            check("lut_inv", 64'(lut_inv), (d > 9) ? 64'd1 : 64'd0);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_xs3", 64'(out_xs3), 64'd0);
        check("rst_out_mask", 64'(out_err_mask), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        check("rst_in_ready1", 64'(in_ready1), 64'd1);

        // Latency and return to IDLE
        out_ready = 1'b1;
        send4(16'h1234, acc);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 64'(n), 64'd4);
        @(posedge clk);
        #1;
        check("in_ready_after_out_hs", 64'(in_ready), 64'd1);
        check("out_valid_after_out_hs", 64'(out_valid), 64'd0);

        send4(16'h9090, acc);
        send4(16'h0000, acc);
        send4(16'h12A4, acc);
        send4(16'hFFFF, acc);
        drain4();

        // Backpressure: result holds, a waiting word is not taken
        out_ready = 1'b0;
        send4(16'h0789, acc);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        in_bcd   = 16'h1111;
        in_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_xs3", 64'(out_xs3), 64'h3ABC);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send4(16'h1111, acc);
        out_ready = 1'b1;
        drain4();

        // Reset in the middle of a word
        send4(16'h5555, acc);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_xs3", 64'(out_xs3), 64'd0);
        check("midrst_out_mask", 64'(out_err_mask), 64'd0);
        check("midrst_out_err", 64'(out_err), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("midrst_no_spurious", 64'(n), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        send4(16'h0001, acc);
        drain4();

        // Streaming with out_ready high: one word every NDIG+2 cycles
        base = seen4;
        for (int i = 0; i < 10; i++) begin
            send4(16'(i), accs[i]);
        end
        for (int i = 1; i < 10; i++) begin
            check("stream4_period", 64'(accs[i] - accs[i-1]), 64'd6);
        end
        drain4();
        check("stream4_count", 64'(seen4 - base), 64'd10);

        // Random words against random sink backpressure
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    w = '0;
                    for (int k = 0; k < 4; k++) begin
                        if ($urandom_range(0, 3) == 0) w[4*k +: 4] = 4'($urandom_range(10, 15));
                        else                           w[4*k +: 4] = 4'($urandom_range(0, 9));
                    end
                    send4(w, acc);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain4();

        // NDIG=1 instance
        out_ready1 = 1'b1;
        send1(4'h7, acc);
        send1(4'hB, acc);
        drain1();
        base = seen1;
        for (int i = 0; i < 10; i++) begin
            send1(4'(i), accs[i]);
        end
        for (int i = 1; i < 10; i++) begin
            check("stream1_period", 64'(accs[i] - accs[i-1]), 64'd3);
        end
        drain1();
        check("stream1_count", 64'(seen1 - base), 64'd10);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_xs3_seq.md
Name: bcd_xs3_seq

Overview:
Sequencing controller that converts a packed multi-digit BCD word to packed Excess-3 using one shared single-digit converter, time-multiplexed one digit per clock. It accepts a word over a valid/ready handshake, walks digits from least significant to most significant, and flags non-BCD nibbles. It then presents the result over a valid/ready handshake. It sits between a BCD source (counter/display path) and Excess-3 consumers in the code-conversion datapath.

Parameters:
NDIG, 4, number of BCD digits per word; legal range 1..16
IDXW, derived = max(1, clog2(NDIG)), digit index width; localparam, not overridable

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  source has a word on in_bcd
in_ready  output  1  block can accept a word
in_bcd  input  4*NDIG  packed BCD; digit k occupies bits [4k+3:4k]
out_valid  output  1  result word available
out_ready  input  1  sink accepts the result
out_xs3  output  4*NDIG  packed Excess-3 result, same digit layout
out_err  output  1  OR of out_err_mask
out_err_mask  output  NDIG  bit k set when input digit k was greater than 9

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n). Reset forces state IDLE, index 0, and all registers 0. Reset values: in_ready=1 once rst_n is high, out_valid=0, out_xs3=0, out_err_mask=0, out_err=0.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, latch in_bcd, clear the result and mask registers, set idx=0, go to CONV.
  - CONV: in_ready=0, out_valid=0. Each cycle, convert digit idx of the latched word and write it into result nibble idx and mask bit idx, then increment idx. When idx==NDIG-1 on that cycle, go to DONE.
  - DONE: out_valid=1, in_ready=0, and out_xs3/out_err_mask hold stable. On out_ready, go to IDLE.
- Latency: an accept on edge t gives out_valid=1 after edge t+NDIG. With out_ready tied high, the next word is accepted no earlier than edge t+NDIG+2. Minimum period is NDIG+2 cycles per word.
- Digit conversion: values 0..9 map to value+3 as a 4-bit result (0→0x3, 9→0xC). Values 10..15 produce 4'b0000 (never X) and set the mask bit.
- out_xs3 and out_err_mask are driven directly from registers. No combinational path exists from in_* to out_*. out_valid and in_ready depend only on state.
- in_bcd changing while the block is in CONV or DONE has no effect, because the word is latched on accept.
- in_valid during CONV or DONE is ignored and not lost; the source holds it per the handshake.
- out_ready held low in DONE: outputs hold indefinitely.
- Handshake rules:
  - out_ready high while out_valid is low has no effect.
  - in_valid low in IDLE keeps the block in IDLE.
- NDIG=1: CONV lasts exactly one cycle.
- Reset asserted in any state, mid-word included: return immediately to reset values. The partial word is discarded and nothing is emitted after release.

Decomposition:
- Shared package bcd_pkg:
  - FSM state enum (IDLE, CONV, DONE) in a 2-bit encoding.
  - Constants XS3_OFFSET=4'd3, BCD_MAX=4'd9, XS3_INVALID=4'd0.
- Sub-module xs3_digit_lut: combinational 4-bit digit in, 4-bit digit out plus invalid flag. It is instantiated once and shared by the sequencer. Verification checks it exhaustively on its own across all 16 codes.

Test Plan:
- NDIG=4, reset then in_bcd=0x1234 with out_ready high → out_valid exactly 4 cycles after the accept edge, out_xs3=0x4567, out_err_mask=0000, out_err=0; in_ready returns one cycle after the out handshake.
- in_bcd=0x9090 → out_xs3=0xC3C3, out_err=0. Then in_bcd=0x0000 → 0x3333.
- in_bcd=0x12A4 → out_xs3=0x4507, out_err_mask=0010, out_err=1. Then in_bcd=0xFFFF → out_xs3=0x0000, mask=1111.
- Backpressure: accept 0x0789, hold out_ready low for 6 cycles → out_valid held, out_xs3=0x3ABC stable, in_ready=0, and in_valid with 0x1111 is not accepted until after out_ready pulses.
- Reset mid-word: accept 0x5555, assert rst_n low after 2 CONV cycles → outputs 0 immediately, in_ready=1 after release, no spurious out_valid. The next word 0x0001 gives 0x3334.
- Back-to-back with in_valid and out_ready tied high, streaming 0x0000..0x0009 → one result every NDIG+2=6 cycles, each result 0x333(3+n), no drops or duplicates. Repeat with NDIG=1 (in 0x7 → 0xA).
